// File: rtl/sys_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sys_bus_arb_pkg
//  Purpose  : Shared definitions for the system bus arbiter. Holds the FSM
//             state encoding, the io_byte_size codes and the default slave
//             region map (SDRAM, TIMER, UART, GPIO).
//  Revision : 1.0  initial release
// ============================================================================
package sys_bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_BEAT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Byte-size codes carried on io_byte_size
    localparam logic [1:0] c_sz_word = 2'd0;
    localparam logic [1:0] c_sz_half = 2'd1;
    localparam logic [1:0] c_sz_byte = 2'd2;

    // Default region map, region 0 in the low 32 bits.
    //   0 SDRAM : 0x0000_0000 - 0x1FFF_FFFF
    //   1 TIMER : 0x2000_xxxx
    //   2 UART  : 0x2001_xxxx
    //   3 GPIO  : 0x2002_xxxx
    localparam logic [127:0] c_def_slv_base = {
        32'h2002_0000, 32'h2001_0000, 32'h2000_0000, 32'h0000_0000
    };
    localparam logic [127:0] c_def_slv_mask = {
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hE000_0000
    };

endpackage
`default_nettype wire

// File: rtl/sys_bus_decode.sv
`default_nettype none
// ============================================================================
//  Module   : sys_bus_decode
//  Purpose  : Combinational address decoder. A region hits when
//             (addr & mask) == base; the lowest-index hit wins.
//  Ports    : i_addr  address to decode
//             o_sel   one-hot region select (all zero on a miss)
//             o_miss  no region hit
//  Revision : 1.0  initial release
// ============================================================================
module sys_bus_decode #(
    parameter int                    XLEN     = 32,
    parameter int                    NSLV     = 4,
    parameter logic [NSLV*XLEN-1:0]  SLV_BASE = '0,
    parameter logic [NSLV*XLEN-1:0]  SLV_MASK = '0
) (
    input  logic [XLEN-1:0] i_addr,
    output logic [NSLV-1:0] o_sel,
    output logic            o_miss
);

    logic [NSLV-1:0] w_hit;

    for (genvar gi = 0; gi < NSLV; gi++) begin : g_hit
        assign w_hit[gi] = ((i_addr & SLV_MASK[gi*XLEN +: XLEN]) == SLV_BASE[gi*XLEN +: XLEN]);
    end

    // Scan from the top down so the lowest index is the last one written.
    always_comb begin
        o_sel  = '0;
        o_miss = 1'b1;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                o_sel    = '0;
                o_sel[i] = 1'b1;
                o_miss   = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sys_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module   : sys_bus_arb
//  Purpose  : Two-master system bus arbiter. m0 issues LINE_WORDS-beat line
//             fills / write-backs, m1 issues single accesses. Round-robin
//             grant, one decode cycle, per-beat io_ready timeout.
//  Ports    : clk, rst (async, active-low)
//             i_m0_* / o_m0_*  refill master (line request, done pulse)
//             i_m1_* / o_m1_*  single-access master (ready pulse)
//             o_io_* / i_io_*  slave side strobes, select, data
//  Revision : 1.0  initial release
// ============================================================================
module sys_bus_arb
    import sys_bus_arb_pkg::*;
#(
    parameter int                   XLEN       = 32,
    parameter int                   LINE_WORDS = 4,
    parameter int                   NSLV       = 4,
    parameter logic [NSLV*XLEN-1:0] SLV_BASE   = c_def_slv_base,
    parameter logic [NSLV*XLEN-1:0] SLV_MASK   = c_def_slv_mask,
    parameter int                   TIMEOUT    = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_m0_req,
    input  logic                       i_m0_we,
    input  logic [XLEN-1:0]            i_m0_addr,
    input  logic [XLEN*LINE_WORDS-1:0] i_m0_wdata,
    output logic [XLEN*LINE_WORDS-1:0] o_m0_rdata,
    output logic                       o_m0_done,
    output logic                       o_m0_err,
    input  logic                       i_m1_req,
    input  logic                       i_m1_we,
    input  logic [XLEN-1:0]            i_m1_addr,
    input  logic [XLEN-1:0]            i_m1_wdata,
    input  logic [1:0]                 i_m1_size,
    output logic [XLEN-1:0]            o_m1_rdata,
    output logic                       o_m1_ready,
    output logic                       o_m1_err,
    output logic [XLEN-1:0]            o_io_addr,
    output logic [XLEN-1:0]            o_io_wdata,
    output logic                       o_io_read,
    output logic                       o_io_write,
    output logic [1:0]                 o_io_byte_size,
    output logic [NSLV-1:0]            o_io_sel,
    input  logic [XLEN-1:0]            i_io_rdata,
    input  logic                       i_io_ready
);

    localparam int c_lw = XLEN * LINE_WORDS;
    localparam int c_bw = $clog2(LINE_WORDS);
    localparam int c_ww = $clog2(TIMEOUT + 1);

    state_t            r_state, w_next;
    logic              r_gnt;       // 0 = m0, 1 = m1
    logic              r_prio;      // master favoured on a simultaneous request
    logic              r_we;
    logic              r_err;
    logic              r_gap;       // idle cycle between beats
    logic [XLEN-1:0]   r_addr;
    logic [c_lw-1:0]   r_wdata;
    logic [1:0]        r_size;
    logic [c_bw-1:0]   r_beat;
    logic [c_ww-1:0]   r_wait;
    logic [c_lw-1:0]   r_m0_rdata;
    logic [XLEN-1:0]   r_m1_rdata;

    logic [NSLV-1:0]   w_sel;
    logic              w_miss;
    logic              w_any_req;
    logic              w_pick;
    logic              w_active;
    logic              w_last;
    logic              w_timeout;

    // Decoding the latched line address is enough: a burst never leaves its region.
    sys_bus_decode #(
        .XLEN     (XLEN),
        .NSLV     (NSLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .i_addr (r_addr),
        .o_sel  (w_sel),
        .o_miss (w_miss)
    );

    assign w_any_req = i_m0_req | i_m1_req;
    assign w_pick    = (i_m0_req & i_m1_req) ? r_prio : i_m1_req;
    assign w_active  = (r_state == ST_BEAT) & ~r_gap;
    assign w_last    = r_gnt | (r_beat == c_bw'(LINE_WORDS - 1));
    assign w_timeout = (r_wait == c_ww'(TIMEOUT - 1));

    // Strobes are decoded from state so an async reset drops them at once.
    assign o_io_read      = w_active & ~r_we;
    assign o_io_write     = w_active &  r_we;
    assign o_io_sel       = w_active ? w_sel : '0;
    assign o_io_addr      = w_active ? (r_addr + XLEN'({r_beat, 2'b00})) : '0;
    assign o_io_wdata     = w_active ? r_wdata[r_beat*XLEN +: XLEN] : '0;
    assign o_io_byte_size = w_active ? r_size : '0;

    assign o_m0_done  = (r_state == ST_DONE) & ~r_gnt;
    assign o_m0_err   = o_m0_done & r_err;
    assign o_m1_ready = (r_state == ST_DONE) &  r_gnt;
    assign o_m1_err   = o_m1_ready & r_err;
    assign o_m0_rdata = r_m0_rdata;
    assign o_m1_rdata = r_m1_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_any_req) w_next = ST_DECODE;
            ST_DECODE: w_next = w_miss ? ST_DONE : ST_BEAT;
            ST_BEAT: begin
                if (w_active) begin
                    if (i_io_ready) begin
                        if (w_last) w_next = ST_DONE;
                    end else if (w_timeout) begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt      <= 1'b0;
            r_prio     <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_gap      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_beat     <= '0;
            r_wait     <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_gnt   <= w_pick;
                        r_we    <= w_pick ? i_m1_we   : i_m0_we;
                        r_addr  <= w_pick ? i_m1_addr : i_m0_addr;
                        r_wdata <= w_pick ? c_lw'(i_m1_wdata) : i_m0_wdata;
                        r_size  <= w_pick ? i_m1_size : c_sz_word;
                        r_beat  <= '0;
                        r_wait  <= '0;
                        r_gap   <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                ST_DECODE: r_err <= w_miss;
                ST_BEAT: begin
                    if (r_gap) begin
                        r_gap  <= 1'b0;
                        r_wait <= '0;
                    end else if (i_io_ready) begin
                        if (!r_we) begin
                            if (r_gnt) r_m1_rdata <= i_io_rdata;
                            else       r_m0_rdata[r_beat*XLEN +: XLEN] <= i_io_rdata;
                        end
                        if (!w_last) begin
                            r_beat <= r_beat + 1'b1;
                            r_gap  <= 1'b1;
                            r_wait <= '0;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_DONE: r_prio <= ~r_gnt;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sys_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sys_bus_arb
//  Purpose  : Directed self-checking bench for sys_bus_arb with a small
//             behavioural slave (zero-wait, never-ready, always-ready modes).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sys_bus_arb;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_m0_req = 0, i_m0_we = 0;
    logic [31:0]  i_m0_addr = 0;
    logic [127:0] i_m0_wdata = 0;
    logic [127:0] o_m0_rdata;
    logic         o_m0_done, o_m0_err;
    logic         i_m1_req = 0, i_m1_we = 0;
    logic [31:0]  i_m1_addr = 0, i_m1_wdata = 0;
    logic [1:0]   i_m1_size = 0;
    logic [31:0]  o_m1_rdata;
    logic         o_m1_ready, o_m1_err;
    logic [31:0]  o_io_addr, o_io_wdata, i_io_rdata;
    logic         o_io_read, o_io_write, i_io_ready;
    logic [1:0]   o_io_byte_size;
    logic [3:0]   o_io_sel;

    int           n_cmp = 0;
    int           n_mis = 0;

    // Slave model: 0 = zero-wait, 1 = never ready, 2 = ready held high always
    int           slv_mode = 0;
    logic [31:0]  slv_mem [4];

    // Monitor log, sampled on the falling edge
    int           nbeats = 0, n_strb = 0, n_m0_done = 0;
    logic [31:0]  b_addr [128];
    logic [31:0]  b_wdata [128];
    logic [1:0]   b_size [128];
    logic [3:0]   b_sel [128];
    logic         b_wr [128];

    sys_bus_arb #(.TIMEOUT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_m0_req       (i_m0_req),
        .i_m0_we        (i_m0_we),
        .i_m0_addr      (i_m0_addr),
        .i_m0_wdata     (i_m0_wdata),
        .o_m0_rdata     (o_m0_rdata),
        .o_m0_done      (o_m0_done),
        .o_m0_err       (o_m0_err),
        .i_m1_req       (i_m1_req),
        .i_m1_we        (i_m1_we),
        .i_m1_addr      (i_m1_addr),
        .i_m1_wdata     (i_m1_wdata),
        .i_m1_size      (i_m1_size),
        .o_m1_rdata     (o_m1_rdata),
        .o_m1_ready     (o_m1_ready),
        .o_m1_err       (o_m1_err),
        .o_io_addr      (o_io_addr),
        .o_io_wdata     (o_io_wdata),
        .o_io_read      (o_io_read),
        .o_io_write     (o_io_write),
        .o_io_byte_size (o_io_byte_size),
        .o_io_sel       (o_io_sel),
        .i_io_rdata     (i_io_rdata),
        .i_io_ready     (i_io_ready)
    );

    always #5 clk = ~clk;

    assign i_io_ready = (slv_mode == 2) || ((slv_mode == 0) && (o_io_read || o_io_write));
    assign i_io_rdata = slv_mem[o_io_addr[3:2]];

    always @(negedge clk) begin
        if (o_io_read || o_io_write) begin
            n_strb++;
            if (i_io_ready && nbeats < 128) begin
                b_addr[nbeats]  = o_io_addr;
                b_wdata[nbeats] = o_io_wdata;
                b_size[nbeats]  = o_io_byte_size;
                b_sel[nbeats]   = o_io_sel;
                b_wr[nbeats]    = o_io_write;
                nbeats++;
            end
        end
        if (o_m0_done) n_m0_done++;
    end

    task automatic chk_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request, scramble the master inputs after grant, wait for completion.
    // Latency is counted in clock edges from the granting edge to the done cycle.
    task automatic do_xfer(input logic m, input logic we, input logic [31:0] addr,
                           input logic [127:0] wdata, input logic [1:0] size,
                           output int lat, output logic err);
        logic got;
        got = 1'b0; lat = 0; err = 1'b0;
        if (m) begin
            i_m1_req = 1; i_m1_we = we; i_m1_addr = addr; i_m1_wdata = wdata[31:0]; i_m1_size = size;
        end else begin
            i_m0_req = 1; i_m0_we = we; i_m0_addr = addr; i_m0_wdata = wdata;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                i_m0_addr = 32'hFFFF_FFFC; i_m0_wdata = ~wdata; i_m0_we = ~we;
                i_m1_addr = 32'hFFFF_FFFC; i_m1_wdata = 32'h0BAD_0BAD; i_m1_we = ~we; i_m1_size = 2'd3;
            end
            if (m ? o_m1_ready : o_m0_done) begin
                got = 1'b1;
                err = m ? o_m1_err : o_m0_err;
            end
        end
        i_m0_req = 0; i_m1_req = 0;
        if (!got) chk_val("xfer_done_seen", 0, 1);
        @(posedge clk); #1;
        chk_val(m ? "m1_ready_pulse" : "m0_done_pulse", m ? o_m1_ready : o_m0_done, 0);
    endtask

    initial begin
        int   lat, s, s2, d0, n_ord, m0_cnt;
        int   ord [4];
        logic err;

        slv_mem = '{32'h0, 32'h0, 32'h0, 32'h0};
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_strobes", {o_io_read, o_io_write}, 0);
        chk_val("rst_sel", o_io_sel, 0);
        chk_val("rst_addr", o_io_addr, 0);
        chk_val("rst_m0_rdata", o_m0_rdata, 0);
        chk_val("rst_m1_rdata", o_m1_rdata, 0);
        chk_val("rst_done", {o_m0_done, o_m1_ready, o_m0_err, o_m1_err}, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // m1 read from SDRAM, zero wait
        slv_mode = 0;
        slv_mem = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0};
        s = nbeats;
        do_xfer(1, 0, 32'h1000_0004, 0, 2'd0, lat, err);
        chk_val("m1rd_lat", lat, 3);
        chk_val("m1rd_err", err, 0);
        chk_val("m1rd_data", o_m1_rdata, 32'hDEAD_BEEF);
        chk_val("m1rd_nbeats", nbeats - s, 1);
        chk_val("m1rd_sel", b_sel[s], 4'b0001);
        chk_val("m1rd_addr", b_addr[s], 32'h1000_0004);

        // m0 fill, slave ready held high through the gaps
        slv_mode = 2;
        slv_mem = '{32'h11, 32'h22, 32'h33, 32'h44};
        s = nbeats; s2 = n_strb;
        do_xfer(0, 0, 32'h0000_0040, 0, 2'd0, lat, err);
        chk_val("fill_lat", lat, 9);
        chk_val("fill_err", err, 0);
        chk_val("fill_nbeats", nbeats - s, 4);
        chk_val("fill_strobe_cycles", n_strb - s2, 4);
        for (int k = 0; k < 4; k++) chk_val("fill_beat_addr", b_addr[s+k], 32'h40 + 4*k);
        chk_val("fill_size", b_size[s+3], 2'd0);
        chk_val("fill_rdata", o_m0_rdata, 128'h00000044_00000033_00000022_00000011);

        // m0 write-back: data per beat, fill data left untouched
        slv_mode = 0;
        s = nbeats;
        do_xfer(0, 1, 32'h0000_0100, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 2'd0, lat, err);
        chk_val("wb_lat", lat, 9);
        chk_val("wb_nbeats", nbeats - s, 4);
        chk_val("wb_wdata0", b_wdata[s], 32'hA0A0_A0A0);
        chk_val("wb_wdata3", b_wdata[s+3], 32'hA3A3_A3A3);
        chk_val("wb_addr3", b_addr[s+3], 32'h0000_010C);
        chk_val("wb_rdata_hold", o_m0_rdata, 128'h00000044_00000033_00000022_00000011);

        // m1 byte write to UART
        s = nbeats;
        do_xfer(1, 1, 32'h2001_0008, 128'h5A, 2'd2, lat, err);
        chk_val("uart_lat", lat, 3);
        chk_val("uart_err", err, 0);
        chk_val("uart_sel", b_sel[s], 4'b0100);
        chk_val("uart_write", b_wr[s], 1);
        chk_val("uart_size", b_size[s], 2'd2);
        chk_val("uart_wdata", b_wdata[s], 32'h5A);
        chk_val("uart_m1_rdata_hold", o_m1_rdata, 32'hDEAD_BEEF);

        // m1 write to an unmapped address
        s2 = n_strb;
        do_xfer(1, 1, 32'hF000_0000, 128'h1, 2'd0, lat, err);
        chk_val("miss_lat", lat, 2);
        chk_val("miss_err", err, 1);
        chk_val("miss_strobes", n_strb - s2, 0);

        // Simultaneous requests; m0 re-requests right after its first completion
        i_m0_req = 1; i_m0_we = 0; i_m0_addr = 32'h40;
        i_m1_req = 1; i_m1_we = 0; i_m1_addr = 32'h1000_0004;
        n_ord = 0; m0_cnt = 0;
        for (int i = 0; i < 100 && n_ord < 3; i++) begin
            @(posedge clk); #1;
            if (o_m0_done) begin
                ord[n_ord] = 0; n_ord++; m0_cnt++;
                if (m0_cnt == 2) i_m0_req = 0;
            end
            if (o_m1_ready && n_ord < 4) begin
                ord[n_ord] = 1; n_ord++; i_m1_req = 0;
            end
        end
        i_m0_req = 0; i_m1_req = 0;
        chk_val("arb_count", n_ord, 3);
        chk_val("arb_first", ord[0], 0);
        chk_val("arb_second", ord[1], 1);
        chk_val("arb_third", ord[2], 0);
        @(posedge clk); #1;

        // Slave never ready: abort after TIMEOUT strobe cycles
        slv_mode = 1;
        s = nbeats; s2 = n_strb;
        do_xfer(0, 0, 32'h0000_0040, 0, 2'd0, lat, err);
        chk_val("to_strobe_cycles", n_strb - s2, 8);
        chk_val("to_lat", lat, 10);
        chk_val("to_err", err, 1);
        chk_val("to_nbeats", nbeats - s, 0);
        slv_mode = 0;

        // Reset during the second beat of a fill
        i_m0_req = 1; i_m0_we = 0; i_m0_addr = 32'h40;
        d0 = n_m0_done;
        repeat (4) @(posedge clk);
        #1;
        chk_val("rst_mid_pre_strobe", o_io_read, 1);
        #2 rst = 1'b0;
        #1;
        chk_val("rst_mid_strobes", {o_io_read, o_io_write}, 0);
        chk_val("rst_mid_sel", o_io_sel, 0);
        i_m0_req = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_mid_no_done", n_m0_done - d0, 0);
        chk_val("rst_mid_rdata", o_m0_rdata, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        slv_mem = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0};
        do_xfer(1, 0, 32'h1000_0004, 0, 2'd0, lat, err);
        chk_val("post_rst_lat", lat, 3);
        chk_val("post_rst_err", err, 0);
        chk_val("post_rst_data", o_m1_rdata, 32'hDEAD_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
